// File: rtl/memory_stage_if.sv
// Request/acknowledge bus between the memory stage and external data memory.
interface memory_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/memory_stage.sv
// MISC-V memory stage: EX/MEM and MEM/WB registers plus a request/ack FSM
// toward data memory, with a bounded wait that force-completes stuck accesses.
module memory_stage #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRegWrite,
  input  logic        IRegStore,
  input  logic        IMemWrite,
  input  logic        IMemRead,
  input  logic [15:0] IALUResult,
  input  logic [15:0] I3rdArg,
  input  logic [15:0] IRd,
  memory_stage_if.master mem,
  output logic        stall,
  output logic [15:0] ALUResultMEM,
  output logic [15:0] ORdM,
  output logic        ORegWriteM,
  output logic [15:0] loadDataWB,
  output logic [15:0] ORdWB,
  output logic        ORegWriteWB,
  output logic        ORegStoreWB,
  output logic        mem_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic        ex_reg_write_q, ex_reg_write_d;
  logic        ex_reg_store_q, ex_reg_store_d;
  logic        ex_mem_write_q, ex_mem_write_d;
  logic        ex_mem_read_q, ex_mem_read_d;
  logic [15:0] ex_alu_q, ex_alu_d;
  logic [15:0] ex_arg3_q, ex_arg3_d;
  logic [15:0] ex_rd_q, ex_rd_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        wb_reg_store_q, wb_reg_store_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [15:0] wb_rd_q, wb_rd_d;
  logic        err_q, err_d;

  logic in_wait, timeout_hit, complete, capture, is_read;

  always_comb begin
    in_wait     = (state_q == S_WAIT);
    timeout_hit = in_wait && (count_q == TIMEOUT_LAST) && !mem.mem_ack;
    complete    = in_wait && (mem.mem_ack || timeout_hit);
    capture     = !in_wait || complete;
    // Both MemRead and MemWrite set is serviced as a write.
    is_read     = ex_mem_read_q && !ex_mem_write_q;
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_reg_store_d = ex_reg_store_q;
    ex_mem_write_d = ex_mem_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    ex_alu_d       = ex_alu_q;
    ex_arg3_d      = ex_arg3_q;
    ex_rd_d        = ex_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_reg_store_d = wb_reg_store_q;
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    err_d          = err_q | timeout_hit;

    if (capture) begin
      ex_reg_write_d = IRegWrite;
      ex_reg_store_d = IRegStore;
      ex_mem_write_d = IMemWrite;
      ex_mem_read_d  = IMemRead;
      ex_alu_d       = IALUResult;
      ex_arg3_d      = I3rdArg;
      ex_rd_d        = IRd;
    end

    // A completing access may hand over directly to the next memory op.
    if (capture && (IMemRead || IMemWrite)) begin
      state_d = S_WAIT;
      count_d = 8'd0;
    end else if (complete) begin
      state_d = S_IDLE;
      count_d = 8'd0;
    end else if (in_wait) begin
      count_d = count_q + 8'd1;
    end

    if (capture) begin
      wb_reg_write_d = ex_reg_write_q;
      wb_reg_store_d = ex_reg_store_q;
      wb_rd_d        = ex_rd_q;
      if (in_wait && is_read)
        wb_data_d = timeout_hit ? 16'h0000 : mem.mem_rdata;
      else
        wb_data_d = ex_alu_q;
    end else begin
      wb_reg_write_d = 1'b0;
      wb_reg_store_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      count_q        <= 8'd0;
      ex_reg_write_q <= 1'b0;
      ex_reg_store_q <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_alu_q       <= 16'h0000;
      ex_arg3_q      <= 16'h0000;
      ex_rd_q        <= 16'h0000;
      wb_reg_write_q <= 1'b0;
      wb_reg_store_q <= 1'b0;
      wb_data_q      <= 16'h0000;
      wb_rd_q        <= 16'h0000;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_reg_store_q <= ex_reg_store_d;
      ex_mem_write_q <= ex_mem_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_alu_q       <= ex_alu_d;
      ex_arg3_q      <= ex_arg3_d;
      ex_rd_q        <= ex_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_reg_store_q <= wb_reg_store_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      err_q          <= err_d;
    end
  end

  assign mem.mem_req   = in_wait;
  assign mem.mem_we    = in_wait && ex_mem_write_q;
  assign mem.mem_addr  = in_wait ? ex_alu_q : 16'h0000;
  assign mem.mem_wdata = in_wait ? ex_arg3_q : 16'h0000;

  assign stall        = in_wait && !complete;
  assign ALUResultMEM = ex_alu_q;
  assign ORdM         = ex_rd_q;
  assign ORegWriteM   = ex_reg_write_q;
  assign loadDataWB   = wb_data_q;
  assign ORdWB        = wb_rd_q;
  assign ORegWriteWB  = wb_reg_write_q;
  assign ORegStoreWB  = wb_reg_store_q;
  assign mem_err      = err_q;

endmodule
